// File: rtl/rv64i_core_top.sv
// rv64i_core_top: single-cycle RV64I integer core with private instruction
// memory, data memory and register file. Programs and register contents are
// loaded by hierarchical backdoor writes to imem, dmem and rf.
// Optional macro RV_DBG_PORTS_EN adds writeback observation outputs
// (dbg_pc, dbg_wb_en, dbg_wb_rd, dbg_wb_data); all read 0 while in reset.
// No handshakes: every rising clk edge retires exactly one instruction.
module rv64i_core_top #(
  parameter int          XLEN        = 64,
  parameter int          IMEM_WORDS  = 4096,
  parameter int          DMEM_DWORDS = 1024,
  parameter logic [63:0] RESET_PC    = 64'h0
) (
  input  logic            clk,
  input  logic            rst_n
`ifdef RV_DBG_PORTS_EN
  ,
  output logic [XLEN-1:0] dbg_pc,
  output logic            dbg_wb_en,
  output logic [4:0]      dbg_wb_rd,
  output logic [XLEN-1:0] dbg_wb_data
`endif
);

  localparam int IMEM_AW = $clog2(IMEM_WORDS);
  localparam int DMEM_AW = $clog2(DMEM_DWORDS);

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;

  // Architectural state; plain unpacked arrays so a bench can load/peek them.
  logic [31:0]     imem [IMEM_WORDS];
  logic [XLEN-1:0] dmem [DMEM_DWORDS];
  logic [XLEN-1:0] rf   [32];
  logic [XLEN-1:0] pc_q, pc_d;

  logic [31:0]     inst;
  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [4:0]      rd, rs1, rs2;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [5:0]      sh6;
  logic [4:0]      sh5;

  logic [XLEN-1:0] mem_addr, mem_addr_al;
  logic [2:0]      lane;
  logic [XLEN-1:0] ld_word, ld_shift;
  logic [7:0]      st_be;
  logic [XLEN-1:0] st_data;
  logic            st_en;

  logic            wb_en_raw, wb_en, take;
  logic [XLEN-1:0] wb_data;

  // Bits of the aligned data address above the dmem index simply alias.
  logic            unused_addr_bits;
  assign unused_addr_bits = ^mem_addr_al[XLEN-1:DMEM_AW+3];

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  assign inst   = imem[pc_q[IMEM_AW+1:2]];
  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign funct7 = inst[31:25];

  // x0 is forced to zero on read regardless of array content.
  assign rs1_val = (rs1 == 5'd0) ? '0 : rf[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 : rf[rs2];

  assign imm_i = {{52{inst[31]}}, inst[31:20]};
  assign imm_s = {{52{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {{32{inst[31]}}, inst[31:12], 12'h000};
  assign imm_j = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  assign sh6 = (opcode == OPC_OPIMM)   ? inst[25:20] : rs2_val[5:0];
  assign sh5 = (opcode == OPC_OPIMM32) ? inst[24:20] : rs2_val[4:0];

  // Data address: force alignment to the access size, then split lane/index.
  always_comb begin
    mem_addr    = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);
    mem_addr_al = mem_addr;
    case (funct3[1:0])
      2'b01:   mem_addr_al[0]   = 1'b0;
      2'b10:   mem_addr_al[1:0] = 2'b00;
      2'b11:   mem_addr_al[2:0] = 3'b000;
      default: mem_addr_al      = mem_addr;
    endcase
    lane     = mem_addr_al[2:0];
    ld_word  = dmem[mem_addr_al[DMEM_AW+2:3]];
    ld_shift = ld_word >> {lane, 3'b000};
    st_data  = rs2_val << {lane, 3'b000};
    case (funct3[1:0])
      2'b00:   st_be = 8'h01 << lane;
      2'b01:   st_be = 8'h03 << lane;
      2'b10:   st_be = 8'h0f << lane;
      default: st_be = 8'hff;
    endcase
  end

  // Decode/execute: writeback value, store request and next pc.
  always_comb begin
    wb_en_raw = 1'b0;
    wb_data   = '0;
    st_en     = 1'b0;
    take      = 1'b0;
    pc_d      = pc_q + 64'd4;
    case (opcode)
      OPC_LUI:   begin wb_en_raw = 1'b1; wb_data = imm_u; end
      OPC_AUIPC: begin wb_en_raw = 1'b1; wb_data = pc_q + imm_u; end
      OPC_JAL: begin
        wb_en_raw = 1'b1;
        wb_data   = pc_q + 64'd4;
        pc_d      = pc_q + imm_j;
      end
      OPC_JALR: begin
        if (funct3 == 3'b000) begin
          wb_en_raw = 1'b1;
          wb_data   = pc_q + 64'd4;
          pc_d      = (rs1_val + imm_i) & ~64'd1;
        end
      end
      OPC_BRANCH: begin
        case (funct3)
          3'b000:  take = (rs1_val == rs2_val);
          3'b001:  take = (rs1_val != rs2_val);
          3'b100:  take = ($signed(rs1_val) <  $signed(rs2_val));
          3'b101:  take = ($signed(rs1_val) >= $signed(rs2_val));
          3'b110:  take = (rs1_val <  rs2_val);
          3'b111:  take = (rs1_val >= rs2_val);
          default: take = 1'b0;
        endcase
        if (take) pc_d = pc_q + imm_b;
      end
      OPC_LOAD: begin
        wb_en_raw = (funct3 != 3'b111);
        case (funct3)
          3'b000:  wb_data = {{56{ld_shift[7]}},  ld_shift[7:0]};
          3'b001:  wb_data = {{48{ld_shift[15]}}, ld_shift[15:0]};
          3'b010:  wb_data = {{32{ld_shift[31]}}, ld_shift[31:0]};
          3'b011:  wb_data = ld_shift;
          3'b100:  wb_data = {56'h0, ld_shift[7:0]};
          3'b101:  wb_data = {48'h0, ld_shift[15:0]};
          3'b110:  wb_data = {32'h0, ld_shift[31:0]};
          default: wb_data = '0;
        endcase
      end
      OPC_STORE: st_en = ~funct3[2];
      OPC_OPIMM: begin
        wb_en_raw = 1'b1;
        case (funct3)
          3'b000: wb_data = rs1_val + imm_i;
          3'b010: wb_data = {63'h0, $signed(rs1_val) < $signed(imm_i)};
          3'b011: wb_data = {63'h0, rs1_val < imm_i};
          3'b100: wb_data = rs1_val ^ imm_i;
          3'b110: wb_data = rs1_val | imm_i;
          3'b111: wb_data = rs1_val & imm_i;
          3'b001: begin
            wb_en_raw = (inst[31:26] == 6'b000000);
            wb_data   = rs1_val << sh6;
          end
          default: begin
            if (inst[31:26] == 6'b000000)      wb_data = rs1_val >> sh6;
            else if (inst[31:26] == 6'b010000) wb_data = $unsigned($signed(rs1_val) >>> sh6);
            else                               wb_en_raw = 1'b0;
          end
        endcase
      end
      OPC_OP: begin
        wb_en_raw = 1'b1;
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  wb_data = rs1_val + rs2_val;
            3'b001:  wb_data = rs1_val << sh6;
            3'b010:  wb_data = {63'h0, $signed(rs1_val) < $signed(rs2_val)};
            3'b011:  wb_data = {63'h0, rs1_val < rs2_val};
            3'b100:  wb_data = rs1_val ^ rs2_val;
            3'b101:  wb_data = rs1_val >> sh6;
            3'b110:  wb_data = rs1_val | rs2_val;
            default: wb_data = rs1_val & rs2_val;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          wb_data = rs1_val - rs2_val;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
          wb_data = $unsigned($signed(rs1_val) >>> sh6);
        end else begin
          wb_en_raw = 1'b0;
        end
      end
      OPC_OPIMM32: begin
        wb_en_raw = 1'b1;
        if (funct3 == 3'b000)                           wb_data = sext32(rs1_val[31:0] + imm_i[31:0]);
        else if (funct3 == 3'b001 && funct7 == 7'h00)   wb_data = sext32(rs1_val[31:0] << sh5);
        else if (funct3 == 3'b101 && funct7 == 7'h00)   wb_data = sext32(rs1_val[31:0] >> sh5);
        else if (funct3 == 3'b101 && funct7 == 7'h20)   wb_data = sext32($unsigned($signed(rs1_val[31:0]) >>> sh5));
        else                                            wb_en_raw = 1'b0;
      end
      OPC_OP32: begin
        wb_en_raw = 1'b1;
        if (funct3 == 3'b000 && funct7 == 7'h00)        wb_data = sext32(rs1_val[31:0] + rs2_val[31:0]);
        else if (funct3 == 3'b000 && funct7 == 7'h20)   wb_data = sext32(rs1_val[31:0] - rs2_val[31:0]);
        else if (funct3 == 3'b001 && funct7 == 7'h00)   wb_data = sext32(rs1_val[31:0] << sh5);
        else if (funct3 == 3'b101 && funct7 == 7'h00)   wb_data = sext32(rs1_val[31:0] >> sh5);
        else if (funct3 == 3'b101 && funct7 == 7'h20)   wb_data = sext32($unsigned($signed(rs1_val[31:0]) >>> sh5));
        else                                            wb_en_raw = 1'b0;
      end
      default: ;
    endcase
  end

  assign wb_en = wb_en_raw && (rd != 5'd0);

  // pc and register file: async reset clears them, otherwise retire one instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      pc_q <= pc_d;
      if (wb_en) rf[rd] <= wb_data;
    end
  end

  // Data memory byte-enabled store; contents survive reset.
  always_ff @(posedge clk) begin
    if (rst_n && st_en) begin
      for (int b = 0; b < 8; b++) begin
        if (st_be[b]) dmem[mem_addr_al[DMEM_AW+2:3]][b*8 +: 8] <= st_data[b*8 +: 8];
      end
    end
  end

`ifdef RV_DBG_PORTS_EN
  assign dbg_pc      = rst_n ? pc_q : '0;
  assign dbg_wb_en   = rst_n & wb_en;
  assign dbg_wb_rd   = (rst_n && wb_en) ? rd : 5'd0;
  assign dbg_wb_data = (rst_n && wb_en) ? wb_data : '0;
`endif

endmodule

// File: tb/tb_rv64i_core_top.sv
// Bench for rv64i_core_top: directed program checks plus random programs
// compared against an instruction-level reference interpreter.
module tb_rv64i_core_top;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

`ifdef RV_DBG_PORTS_EN
  logic [63:0] dbg_pc;
  logic        dbg_wb_en;
  logic [4:0]  dbg_wb_rd;
  logic [63:0] dbg_wb_data;
`endif

  rv64i_core_top dut (
    .clk   (clk),
    .rst_n (rst_n)
`ifdef RV_DBG_PORTS_EN
    ,
    .dbg_pc      (dbg_pc),
    .dbg_wb_en   (dbg_wb_en),
    .dbg_wb_rd   (dbg_wb_rd),
    .dbg_wb_data (dbg_wb_data)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_imem [4096];
  logic [63:0] m_dmem [1024];
  logic [63:0] m_rf   [32];
  logic [63:0] m_pc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [19:0] imm);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [7:0] get_byte(input logic [63:0] addr);
    logic [63:0] w;
    w = m_dmem[addr[12:3]];
    return w[addr[2:0]*8 +: 8];
  endfunction

  task automatic put_byte(input logic [63:0] addr, input logic [7:0] val);
    logic [63:0] w;
    w = m_dmem[addr[12:3]];
    w[addr[2:0]*8 +: 8] = val;
    m_dmem[addr[12:3]] = w;
  endtask

  // Executes one instruction on the model: byte-wise memory, plain arithmetic.
  task automatic model_step();
    logic [31:0] ins;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [63:0] a, b, ii, is_, ib, iu, res, nxt, addr, v;
    logic        we, take;
    int          n;
    ins = m_imem[m_pc[13:2]];
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25]; rd = ins[11:7];
    a = m_rf[ins[19:15]]; b = m_rf[ins[24:20]];
    ii  = {{52{ins[31]}}, ins[31:20]};
    is_ = {{52{ins[31]}}, ins[31:25], ins[11:7]};
    ib  = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    iu  = {{32{ins[31]}}, ins[31:12], 12'h000};
    res = 64'h0; we = 1'b0; take = 1'b0; nxt = m_pc + 64'd4;
    case (op)
      7'h37: begin res = iu; we = 1'b1; end
      7'h17: begin res = m_pc + iu; we = 1'b1; end
      7'h63: begin
        case (f3)
          3'd0: take = (a == b);
          3'd1: take = (a != b);
          3'd4: take = ($signed(a) < $signed(b));
          3'd5: take = ($signed(a) >= $signed(b));
          3'd6: take = (a < b);
          3'd7: take = (a >= b);
          default: take = 1'b0;
        endcase
        if (take) nxt = m_pc + ib;
      end
      7'h03: if (f3 != 3'd7) begin
        n = 1 << f3[1:0];
        addr = (a + ii) & ~(64'(n) - 64'd1);
        v = 64'h0;
        for (int k = 0; k < n; k++) v = v | (64'(get_byte(addr + 64'(k))) << (8 * k));
        if (!f3[2] && n < 8 && v[8*n-1]) v = v | (~64'h0 << (8 * n));
        res = v; we = 1'b1;
      end
      7'h23: if (!f3[2]) begin
        n = 1 << f3[1:0];
        addr = (a + is_) & ~(64'(n) - 64'd1);
        for (int k = 0; k < n; k++) put_byte(addr + 64'(k), b[8*k +: 8]);
      end
      7'h13: begin
        we = 1'b1;
        case (f3)
          3'd0: res = a + ii;
          3'd1: res = a << ins[25:20];
          3'd2: res = {63'h0, $signed(a) < $signed(ii)};
          3'd3: res = {63'h0, a < ii};
          3'd4: res = a ^ ii;
          3'd5: res = ins[30] ? $unsigned($signed(a) >>> ins[25:20]) : (a >> ins[25:20]);
          3'd6: res = a | ii;
          default: res = a & ii;
        endcase
      end
      7'h33: begin
        we = 1'b1;
        case (f3)
          3'd0: res = f7[5] ? a - b : a + b;
          3'd1: res = a << b[5:0];
          3'd2: res = {63'h0, $signed(a) < $signed(b)};
          3'd3: res = {63'h0, a < b};
          3'd4: res = a ^ b;
          3'd5: res = f7[5] ? $unsigned($signed(a) >>> b[5:0]) : (a >> b[5:0]);
          3'd6: res = a | b;
          default: res = a & b;
        endcase
      end
      7'h1b: begin
        we = 1'b1;
        case (f3)
          3'd0: res = sx32(a[31:0] + ii[31:0]);
          3'd1: res = sx32(a[31:0] << ins[24:20]);
          default: res = ins[30] ? sx32($unsigned($signed(a[31:0]) >>> ins[24:20]))
                                 : sx32(a[31:0] >> ins[24:20]);
        endcase
      end
      7'h3b: begin
        we = 1'b1;
        case (f3)
          3'd0: res = f7[5] ? sx32(a[31:0] - b[31:0]) : sx32(a[31:0] + b[31:0]);
          3'd1: res = sx32(a[31:0] << b[4:0]);
          default: res = f7[5] ? sx32($unsigned($signed(a[31:0]) >>> b[4:0]))
                               : sx32(a[31:0] >> b[4:0]);
        endcase
      end
      default: ;
    endcase
    if (we && rd != 5'd0) m_rf[rd] = res;
    m_pc = nxt;
  endtask

  // ---------------- program helpers ----------------
  task automatic clear_imem();
    for (int i = 0; i < 4096; i++) begin
      m_imem[i] = 32'h0;
      dut.imem[i] = 32'h0;
    end
  endtask

  task automatic gen_random_program(input int len);
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [31:0] ins;
    int          kind, sel;
    logic [2:0]  op_f3 [10] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
    logic [6:0]  op_f7 [10] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00, 7'h00};
    logic [2:0]  w_f3 [5]   = '{3'd0, 3'd0, 3'd1, 3'd5, 3'd5};
    logic [6:0]  w_f7 [5]   = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h20};
    logic [2:0]  br_f3 [6]  = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    for (int i = 0; i < len; i++) begin
      rd = 5'($urandom_range(0, 31));
      if (rd == 5'd3) rd = 5'd4;
      rs1 = 5'($urandom_range(0, 31));
      rs2 = 5'($urandom_range(0, 31));
      imm = 12'($urandom);
      kind = $urandom_range(0, 7);
      case (kind)
        0: begin
          sel = $urandom_range(0, 9);
          ins = enc_r(7'h33, op_f3[sel], op_f7[sel], rd, rs1, rs2);
        end
        1: begin
          f3 = 3'($urandom_range(0, 7));
          if (f3 == 3'd1) imm = {6'h00, imm[5:0]};
          if (f3 == 3'd5) imm = {imm[10] ? 6'h10 : 6'h00, imm[5:0]};
          ins = enc_i(7'h13, f3, rd, rs1, imm);
        end
        2: begin
          sel = $urandom_range(0, 4);
          ins = enc_r(7'h3b, w_f3[sel], w_f7[sel], rd, rs1, rs2);
        end
        3: begin
          sel = $urandom_range(0, 3);
          case (sel)
            0: ins = enc_i(7'h1b, 3'd0, rd, rs1, imm);
            1: ins = enc_i(7'h1b, 3'd1, rd, rs1, {7'h00, imm[4:0]});
            2: ins = enc_i(7'h1b, 3'd5, rd, rs1, {7'h00, imm[4:0]});
            default: ins = enc_i(7'h1b, 3'd5, rd, rs1, {7'h20, imm[4:0]});
          endcase
        end
        4: ins = enc_i(7'h03, 3'($urandom_range(0, 6)), rd, 5'd3, 12'($urandom_range(0, 255)));
        5: ins = enc_s(3'($urandom_range(0, 3)), 5'd3, rs2, 12'($urandom_range(0, 255)));
        6: ins = enc_b(br_f3[$urandom_range(0, 5)], rs1, rs2, 13'd8);
        default: ins = enc_u($urandom_range(0, 1) ? 7'h37 : 7'h17, rd, 20'($urandom));
      endcase
      m_imem[i] = ins;
      dut.imem[i] = ins;
    end
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] dprog [20];
  logic [63:0] pc_exp [17] = '{64'h04, 64'h08, 64'h0c, 64'h10, 64'h14, 64'h18, 64'h1c,
                               64'h20, 64'h28, 64'h2c, 64'h30, 64'h34, 64'h38, 64'h3c,
                               64'h40, 64'h4c, 64'h44};
  logic [63:0] v64;

  initial begin
    // ---- 1: reset then NOP stream ----
    clear_imem();
    for (int i = 0; i < 16; i++) dut.imem[i] = enc_i(7'h13, 3'd0, 5'd0, 5'd0, 12'h0);
    do_reset();
    check("reset_pc", dut.pc_q, 64'h0);
    check("reset_rf", dut.rf[9], 64'h0);
    dut.rf[7] = 64'h0123456789abcdef;
    tick(5);
    check("nop_pc", dut.pc_q, 64'd20);
    check("nop_rf", dut.rf[7], 64'h0123456789abcdef);

    // ---- 2: directed program ----
    clear_imem();
    dprog[0]  = enc_i(7'h13, 3'd0, 5'd5, 5'd2, 12'hff0);
    dprog[1]  = enc_u(7'h37, 5'd6, 20'h80000);
    dprog[2]  = enc_s(3'd3, 5'd3, 5'd2, 12'h0);
    dprog[3]  = enc_i(7'h03, 3'd2, 5'd7, 5'd3, 12'd4);
    dprog[4]  = enc_i(7'h03, 3'd4, 5'd8, 5'd3, 12'd0);
    dprog[5]  = enc_i(7'h03, 3'd0, 5'd9, 5'd3, 12'd3);
    dprog[6]  = enc_i(7'h1b, 3'd0, 5'd11, 5'd10, 12'd1);
    dprog[7]  = enc_r(7'h3b, 3'd5, 7'h20, 5'd12, 5'd11, 5'd1);
    dprog[8]  = enc_b(3'd4, 5'd6, 5'd0, 13'd8);
    dprog[9]  = enc_i(7'h13, 3'd0, 5'd13, 5'd0, 12'd1);
    dprog[10] = enc_b(3'd6, 5'd6, 5'd0, 13'd8);
    dprog[11] = enc_i(7'h13, 3'd0, 5'd14, 5'd0, 12'd2);
    dprog[12] = enc_i(7'h13, 3'd0, 5'd0, 5'd0, 12'd5);
    dprog[13] = enc_i(7'h13, 3'd0, 5'd0, 5'd0, 12'd0);
    dprog[14] = dprog[13];
    dprog[15] = dprog[13];
    dprog[16] = enc_j(5'd1, 21'd12);
    dprog[17] = dprog[13];
    dprog[18] = dprog[13];
    dprog[19] = enc_i(7'h67, 3'd0, 5'd0, 5'd1, 12'd0);
    for (int i = 0; i < 20; i++) dut.imem[i] = dprog[i];
    dut.dmem[0] = 64'hdeadbeefcafef00d;
    do_reset();
    dut.rf[1]  = 64'd4;
    dut.rf[2]  = 64'h7ffffff0;
    dut.rf[3]  = 64'h10000000;
    dut.rf[10] = 64'h7fffffff;
`ifdef RV_DBG_PORTS_EN
    check("dbg_wb_en", {63'h0, dbg_wb_en}, 64'h1);
    check("dbg_wb_rd", {59'h0, dbg_wb_rd}, 64'd5);
    check("dbg_wb_data", dbg_wb_data, 64'h7fffffe0);
`endif
    for (int i = 0; i < 17; i++) begin
      tick(1);
      check($sformatf("dir_pc%0d", i + 1), dut.pc_q, pc_exp[i]);
    end
    check("addi_x5", dut.rf[5], 64'h7fffffe0);
    check("lui_x6", dut.rf[6], 64'hffffffff80000000);
    check("lw_x7", dut.rf[7], 64'h0);
    check("lbu_x8", dut.rf[8], 64'hf0);
    check("lb_x9", dut.rf[9], 64'h7f);
    v64 = (64'h10000000 >> 3) % 64'd1024;
    check("sd_dmem", dut.dmem[v64[9:0]], 64'h000000007ffffff0);
    check("addiw_x11", dut.rf[11], 64'hffffffff80000000);
    check("sraw_x12", dut.rf[12], 64'hfffffffff8000000);
    check("blt_skip_x13", dut.rf[13], 64'h0);
    check("bltu_fall_x14", dut.rf[14], 64'd2);
    check("x0_zero", dut.rf[0], 64'h0);
    check("jal_link_x1", dut.rf[1], 64'h44);

    // ---- 3: async reset mid-program ----
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_pc", dut.pc_q, 64'h0);
    check("midrst_rf", dut.rf[5], 64'h0);
    check("midrst_dmem", dut.dmem[0], 64'h000000007ffffff0);
`ifdef RV_DBG_PORTS_EN
    check("midrst_dbg_pc", dbg_pc, 64'h0);
    check("midrst_dbg_en", {63'h0, dbg_wb_en}, 64'h0);
`endif
    @(negedge clk);
    @(negedge clk);
    check("rst_hold_pc", dut.pc_q, 64'h0);
    rst_n = 1'b1;

    // ---- 4: random programs against the reference model ----
    for (int t = 0; t < 4; t++) begin
      clear_imem();
      gen_random_program(40);
      for (int i = 'h200; i < 'h230; i++) begin
        v64 = {$urandom, $urandom};
        m_dmem[i] = v64;
        dut.dmem[i] = v64;
      end
      do_reset();
      m_pc = 64'h0;
      m_rf[0] = 64'h0;
      for (int r = 1; r < 32; r++) begin
        v64 = {$urandom, $urandom};
        if (r == 3) v64 = 64'h1000 + 64'(8 * $urandom_range(0, 7));
        m_rf[r] = v64;
        dut.rf[r] = v64;
      end
      for (int c = 0; c < 48; c++) begin
        tick(1);
        model_step();
        check($sformatf("rnd%0d_pc_c%0d", t, c), dut.pc_q, m_pc);
      end
      for (int r = 0; r < 32; r++) check($sformatf("rnd%0d_x%0d", t, r), dut.rf[r], m_rf[r]);
      for (int i = 'h200; i < 'h230; i++)
        check($sformatf("rnd%0d_dmem%0h", t, i), dut.dmem[i], m_dmem[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv64i_core_top.md
Name: rv64i_core_top

Overview:
- Single-cycle RV64I integer core with private instruction memory, data memory and register file; self-contained.
- Only top-level inputs are clock and reset.
- Programs and initial register values are loaded by backdoor, writing directly to the internal arrays.
- Top of the core subsystem; the integration level adds any debug observation.

Parameters:
- XLEN, 64, datapath and register width (fixed 64; parameter for readability only).
- IMEM_WORDS, 4096, instruction memory depth in 32-bit words.
- DMEM_DWORDS, 1024, data memory depth in 64-bit doublewords.
- RESET_PC, 64'h0, PC value loaded on reset.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0, async):
  - pc=RESET_PC.
  - rf[1..31] cleared to 0.
  - Memories are not cleared.
  - Backdoor writes to rf or memories made after rst_n deasserts and before the first rising edge must persist.
- Internal state, as plain unpacked arrays for backdoor load/peek:
  - imem[IMEM_WORDS] of 32 bits.
  - dmem[DMEM_DWORDS] of 64 bits.
  - rf[32] of 64 bits.
- Register file:
  - rf[0] always reads 0; writes to x0 are ignored.
  - Two async read ports, one synchronous write port.
- Timing: single cycle, one instruction retires per rising clk edge.
  - Fetch: imem[pc[IMEM_AW+1:2]]; PC bits above the index wrap (alias).
  - Decode, execute, memory and writeback complete combinationally; rf write, dmem write and pc update occur on the same edge.
- ISA supported:
  - LUI, AUIPC, JAL, JALR.
  - BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - LB, LH, LW, LD, LBU, LHU, LWU.
  - SB, SH, SW, SD.
  - ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI (6-bit shamt).
  - ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA (shift by rs2[5:0]).
  - ADDIW, SLLIW, SRLIW, SRAIW, ADDW, SUBW, SLLW, SRLW, SRAW: compute on low 32 bits, shift amount [4:0], result sign-extended from bit 31.
- Immediates: I/S/B/U/J formats, sign-extended to 64 bits.
- Control flow:
  - JALR target = (rs1+imm) & ~1.
  - JAL/JALR write pc+4 to rd.
  - Branch/jump targets use pc of the current instruction; default next pc = pc+4.
- Data memory:
  - Byte address A selects doubleword dmem[A[DMEM_AW+2:3]] (upper address bits alias/wrap), byte lane A[2:0].
  - Stores use byte enables; unwritten bytes are preserved.
  - Loads extract the lane, then sign- or zero-extend.
  - Misaligned access: low address bits are forced to the access size alignment (H: A[0]=0, W: A[1:0]=0, D: A[2:0]=0); no trap.
- FENCE, ECALL, EBREAK, and any unrecognised opcode execute as NOP: pc+4, no state change.
- Reset mid-run: pc returns to RESET_PC immediately (async); rf cleared; memory contents retained.

Optional Feature:
- Macro RV_DBG_PORTS_EN.
- Defined: adds outputs dbg_pc (64, pc of retiring instruction), dbg_wb_en (1), dbg_wb_rd (5) and dbg_wb_data (64), reflecting the writeback of the instruction retiring at the next edge.
  - dbg_wb_en is 0 for x0 destinations and for non-writing instructions.
  - All debug outputs read 0 while rst_n=0.
- Undefined: ports absent; behaviour otherwise identical.

Test Plan:
- Reset, then NOP stream (ADDI x0,x0,0) -> pc=0 after reset, pc=4*N after N edges; rf unchanged.
- rf[2]=64'h7ffffff0 preloaded; ADDI x5,x2,-16 -> x5=64'h7fffffe0; LUI x6,0x80000 -> x6=64'hffffffff80000000.
- rf[3]=64'h10000000; SD x2,0(x3), then LW x7,4(x3), LBU x8,0(x3), LB x9,3(x3):
  - x7=0.
  - x8=64'hf0.
  - x9=64'h7f.
  - dmem[0x10000000 aliased index] = 64'h000000007ffffff0.
- x10=64'h7fffffff; ADDIW x11,x10,1 -> x11=64'hffffffff80000000; SRAW x12,x11,x1 (x1=4) -> x12=64'hfffffffff8000000.
- Branches: BLT x6,x0,+8 taken (skips one instruction); BLTU x6,x0 not taken; JAL x1,+12 at pc=0x40 -> x1=0x44, pc=0x4c; JALR x0,0(x1) -> pc=0x44.
- Write to x0 (ADDI x0,x0,5) -> x0 reads 0; assert rst_n low mid-program -> pc=0 immediately, dmem retained.
